uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter; successor to the fixed 8N1 Tx FSM.
//  Serialises one word per frame: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
//  Each bit lasts CLKS_PER_BIT clocks from an internal baud counter. Handshake is send/bussy with a done pulse.
//  Sits between the register/GPIO front end and the UART pin.
// PARAMETERS
//  DATA_BITS     8   data bits per frame, legal 5..9
//  CLKS_PER_BIT  16  clocks per serial bit, legal >=1
//  PARITY        0   0 = none, 1 = odd, 2 = even
//  STOP_BITS     1   stop bits per frame, legal 1 or 2
// PORTS
//  clk    in   1          system clock, all logic on posedge
//  reset  in   1          synchronous, active-high reset
//  send   in   1          request to transmit data; sampled only in IDLE
//  data   in   DATA_BITS  word to send; latched on accept
//  out    out  1          serial line, registered, idle high
//  bussy  out  1          high while a frame is in progress
//  done   out  1          one-cycle pulse after a frame's last stop bit
// BEHAVIOUR
//  Reset:
//   - reset=1 at an edge -> next cycle state=IDLE, out=1, bussy=0, done=0.
//   - Reset clears the shift register, bit counter and baud counter.
//   - Reset overrides all other inputs.
//  States: IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE.
//  Accept:
//   - Edge T0 with state=IDLE and send=1 latches data.
//   - From T0+1: bussy=1 and out=0 (start bit).
//  Timing:
//   - Every bit holds for exactly CLKS_PER_BIT cycles.
//   - Baud counter width is $clog2(CLKS_PER_BIT), min 1. It restarts at 0 on every bit boundary.
//  DATA:
//   - out = latched bit i, for i = 0..DATA_BITS-1.
//   - Bit counter width is $clog2(DATA_BITS+1). No wrap past DATA_BITS-1.
//  PARITY:
//   - odd: parity bit = ~^latched; even: parity bit = ^latched. Parity covers data bits only.
//  STOP: out=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  Frame end:
//   - Frame length F = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
//   - Cycle T0+F+1 is IDLE with bussy=0, out=1 and done=1 for that single cycle.
//  Ordering and changes during a frame:
//   - send while bussy=1 is ignored; no queueing.
//   - data changes after T0 have no effect on the current frame.
//   - send held high gives back-to-back frames with exactly one idle-high cycle between them (the done cycle).
//  Reset mid-frame: line returns high the next cycle, no done pulse, frame discarded.
//  out, bussy and done are flop outputs, glitch-free. No combinational path from inputs to outputs.
// TESTING
//  1 reset 2 cycles, send=0 -> out=1, bussy=0, done=0; held for 20 idle cycles.
//  2 DATA_BITS=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5 one cycle
//    -> out = 0,1,0,1,0,0,1,0,1,1, each 4 cycles
//    -> bussy high 40 cycles, then done pulse, bussy=0.
//  3 PARITY=2, send 0x07 -> parity bit 1. PARITY=1, send 0x07 -> parity bit 0. Frame is 44 cycles at CLKS=4.
//  4 STOP_BITS=2, send held high with data 0x3C then 0xC3 -> two frames, stop high 8 cycles, 1 idle cycle between frames.
//    Pulsing send mid-frame does not start a new frame.
//  5 reset asserted during data bit 3 -> out=1, bussy=0 next cycle, no done; next send gives a correct full frame.
//  6 CLKS_PER_BIT=1, DATA_BITS=5, send 0x15 -> one bit per clock, sequence 0,1,0,1,0,1,1, then done.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// one or two stop bits, each bit held for CLKS_PER_BIT clocks. All outputs are flops.
module uart_tx_cfg #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 send_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 out_o,
    output logic                 bussy_o,
    output logic                 done_o
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state_q;
    logic [BaudW-1:0]       baud_q;
    logic [BitW-1:0]        bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   out_q;
    logic                   bussy_q;
    logic                   done_q;

    logic                   bit_end;
    logic                   par_calc;

    assign bit_end = (baud_q == BaudLast);

    // Parity is computed from the word as accepted, so later data changes cannot leak in.
    always_comb begin
        par_calc = ^data_i;
        if (PARITY == 1) begin
            par_calc = ~^data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            bussy_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (send_i) begin
                        shift_q <= data_i;
                        par_q   <= par_calc;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        out_q   <= 1'b0;
                        bussy_q <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        out_q   <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == DataLast) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                out_q   <= par_q;
                                state_q <= StParity;
                            end else begin
                                out_q   <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            // Bit i+1 sits at index 1 before this shift moves it down.
                            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                            out_q   <= shift_q[1];
                            bit_q   <= bit_q + BitW'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        out_q   <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == StopLast) begin
                            bit_q   <= '0;
                            out_q   <= 1'b1;
                            bussy_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            bit_q <= bit_q + BitW'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    out_q   <= 1'b1;
                    bussy_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_o   = out_q;
    assign bussy_o = bussy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five configurations share one clock; every cycle of each frame is
// compared with a frame model built from the word, the parameters and plain arithmetic.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic [4:0] rst;
    logic [4:0] snd;
    logic [8:0] dat [5];
    logic [4:0] ow;
    logic [4:0] bw;
    logic [4:0] dw;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_i(clk), .reset_i(rst[0]), .send_i(snd[0]), .data_i(dat[0][7:0]),
        .out_o(ow[0]), .bussy_o(bw[0]), .done_o(dw[0]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk_i(clk), .reset_i(rst[1]), .send_i(snd[1]), .data_i(dat[1][7:0]),
        .out_o(ow[1]), .bussy_o(bw[1]), .done_o(dw[1]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk_i(clk), .reset_i(rst[2]), .send_i(snd[2]), .data_i(dat[2][7:0]),
        .out_o(ow[2]), .bussy_o(bw[2]), .done_o(dw[2]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk_i(clk), .reset_i(rst[3]), .send_i(snd[3]), .data_i(dat[3][7:0]),
        .out_o(ow[3]), .bussy_o(bw[3]), .done_o(dw[3]));
    uart_tx_cfg #(.DATA_BITS(5), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) u4 (
        .clk_i(clk), .reset_i(rst[4]), .send_i(snd[4]), .data_i(dat[4][4:0]),
        .out_o(ow[4]), .bussy_o(bw[4]), .done_o(dw[4]));

    function automatic int db_of(input int k);
        return (k == 4) ? 5 : 8;
    endfunction

    function automatic int cpb_of(input int k);
        return (k == 4) ? 1 : 4;
    endfunction

    function automatic int par_of(input int k);
        return (k == 1) ? 2 : (k == 2) ? 1 : 0;
    endfunction

    function automatic int sb_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int flen(input int k);
        return (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k)) * cpb_of(k);
    endfunction

    // Line level of bit slot idx (0 = start bit) for word w on configuration k.
    function automatic logic exp_bit(input int k, input logic [8:0] w, input int idx);
        int db;
        int ones;
        db   = db_of(k);
        ones = 0;
        for (int i = 0; i < db; i++) ones += int'(w[i]);
        if (idx == 0) return 1'b0;
        if (idx <= db) return w[idx-1];
        if (par_of(k) == 2 && idx == db + 1) return ((ones % 2) == 1);
        if (par_of(k) == 1 && idx == db + 1) return ((ones % 2) == 0);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int k, input string tag, input logic exp_done);
        chk($sformatf("%s_out_u%0d", tag, k), ow[k], 1'b1);
        chk($sformatf("%s_bussy_u%0d", tag, k), bw[k], 1'b0);
        chk($sformatf("%s_done_u%0d", tag, k), dw[k], exp_done);
    endtask

    // Called at a negedge; the following posedge is the accept edge. chain keeps send high
    // through the done cycle so the next call starts a back-to-back frame.
    task automatic run_frame(input int k, input logic [8:0] w, input bit chain, input bit noisy,
                             input string tag);
        int f;
        int cpb;
        f       = flen(k);
        cpb     = cpb_of(k);
        snd[k]  = 1'b1;
        dat[k]  = w;
        for (int c = 1; c <= f; c++) begin
            @(negedge clk);
            chk($sformatf("%s_out_c%0d", tag, c), ow[k], exp_bit(k, w, (c - 1) / cpb));
            chk($sformatf("%s_bussy_c%0d", tag, c), bw[k], 1'b1);
            chk($sformatf("%s_done_c%0d", tag, c), dw[k], 1'b0);
            if (chain) snd[k] = 1'b1;
            else if (noisy) snd[k] = 1'($urandom_range(0, 1));
            else snd[k] = 1'b0;
            if (noisy) dat[k] = 9'($urandom);
        end
        @(negedge clk);
        check_idle(k, {tag, "_end"}, 1'b1);
        if (!chain) snd[k] = 1'b0;
    endtask

    initial begin
        rst = '1;
        snd = '0;
        for (int k = 0; k < 5; k++) dat[k] = '0;

        // Reset for two cycles, then 20 idle cycles on every configuration.
        @(negedge clk);
        @(negedge clk);
        rst = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 5; k++) check_idle(k, "idle", 1'b0);
        end

        run_frame(0, 9'h0A5, 1'b0, 1'b0, "a5");
        @(negedge clk);
        check_idle(0, "a5_after", 1'b0);

        run_frame(1, 9'h007, 1'b0, 1'b0, "even07");
        run_frame(2, 9'h007, 1'b0, 1'b0, "odd07");

        run_frame(3, 9'h03C, 1'b1, 1'b0, "b2b_3c");
        run_frame(3, 9'h0C3, 1'b0, 1'b0, "b2b_c3");
        @(negedge clk);
        check_idle(3, "b2b_after", 1'b0);
        run_frame(3, 9'($urandom), 1'b0, 1'b1, "noisy2stop");

        // Reset during data bit 3 (cycles 17..20 of the frame) with send held high.
        snd[0] = 1'b1;
        dat[0] = 9'h05A;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            chk($sformatf("pre_rst_out_c%0d", c), ow[0], exp_bit(0, 9'h05A, (c - 1) / 4));
            snd[0] = 1'b1;
            dat[0] = 9'($urandom);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        check_idle(0, "rst_mid", 1'b0);
        rst[0] = 1'b0;
        snd[0] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check_idle(0, "post_rst", 1'b0);
        end
        run_frame(0, 9'h0A5, 1'b0, 1'b0, "after_rst");

        run_frame(4, 9'h015, 1'b0, 1'b0, "fast15");
        @(negedge clk);
        check_idle(4, "fast_after", 1'b0);

        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                run_frame(k, 9'($urandom), 1'b0, 1'b1, $sformatf("rnd_u%0d_%0d", k, i));
                @(negedge clk);
                check_idle(k, "rnd_gap", 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
